// File: rtl/button_pkg.sv
// Shared key indices, code widths and repeat-FSM states for the front-panel button path.
package button_pkg;

  localparam int NUM_KEYS   = 9;
  localparam int KEY_CODE_W = 4;

  localparam logic [KEY_CODE_W-1:0] KEY_AU   = 4'd0;
  localparam logic [KEY_CODE_W-1:0] KEY_DIS  = 4'd1;
  localparam logic [KEY_CODE_W-1:0] KEY_L    = 4'd2;
  localparam logic [KEY_CODE_W-1:0] KEY_R    = 4'd3;
  localparam logic [KEY_CODE_W-1:0] KEY_F    = 4'd4;
  localparam logic [KEY_CODE_W-1:0] KEY_PRH  = 4'd5;
  localparam logic [KEY_CODE_W-1:0] KEY_PRF  = 4'd6;
  localparam logic [KEY_CODE_W-1:0] KEY_PRC  = 4'd7;
  localparam logic [KEY_CODE_W-1:0] KEY_ICR  = 4'd8;
  localparam logic [KEY_CODE_W-1:0] KEY_NONE = 4'hF;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    REPEAT
  } rpt_state_t;

  // Lowest set index wins; KEY_NONE when nothing is set.
  function automatic logic [KEY_CODE_W-1:0] first_key(input logic [NUM_KEYS-1:0] v);
    first_key = KEY_NONE;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (v[i]) first_key = KEY_CODE_W'(i);
    end
  endfunction

endpackage

// File: rtl/key_repeat_timer.sv
// Auto-repeat FSM and counter for keys 0/1: HOLD_CYCLES to the first repeat, then every REPEAT_CYCLES.
module key_repeat_timer
  import button_pkg::*;
#(
  parameter int HOLD_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 10_000_000
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_start,
  input  logic       i_key,
  input  logic [1:0] i_level,
  input  logic       i_abort,
  output logic       o_repeat,
  output logic       o_key
);

  localparam int MAX_CYCLES = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

  rpt_state_t       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_trk, w_trk_nxt;
  logic             w_repeat;
  logic             w_level;

  assign w_level  = i_level[r_trk];
  assign o_repeat = w_repeat;
  assign o_key    = r_trk;

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_trk   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_trk   <= w_trk_nxt;
    end
  end

  // A fresh rise always overrides the timer, which also suppresses a coincident repeat.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_trk_nxt   = r_trk;
    w_repeat    = 1'b0;
    if (i_start) begin
      w_state_nxt = HOLD;
      w_cnt_nxt   = '0;
      w_trk_nxt   = i_key;
    end else if (i_abort) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        IDLE: begin
          w_cnt_nxt = '0;
        end
        HOLD: begin
          if (!w_level) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
          end else if (r_cnt == HOLD_LAST) begin
            w_repeat    = 1'b1;
            w_state_nxt = REPEAT;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        REPEAT: begin
          if (!w_level) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
          end else if (r_cnt == REPEAT_LAST) begin
            w_repeat  = 1'b1;
            w_cnt_nxt = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/button_event_encoder.sv
// Turns debounced button levels into single key events under valid/ready.
// Define AUTOREPEAT_EN to build the timed auto-repeat for keys 0 and 1.
module button_event_encoder
  import button_pkg::*;
#(
  parameter int HOLD_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 10_000_000
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [NUM_KEYS-1:0]   i_btn_lvl,
  input  logic                  i_evt_ready,
  output logic                  o_evt_valid,
  output logic [KEY_CODE_W-1:0] o_evt_code,
  output logic                  o_evt_rpt,
  output logic                  o_evt_ovf
);

  if (HOLD_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_bad_param
    $error("HOLD_CYCLES and REPEAT_CYCLES must both be at least 2");
  end

  logic [NUM_KEYS-1:0]   r_prev;
  logic                  r_evt_valid;
  logic [KEY_CODE_W-1:0] r_evt_code;
  logic                  r_evt_rpt;
  logic                  r_evt_ovf;

  logic [NUM_KEYS-1:0]   w_rise;
  logic                  w_rise_any;
  logic [KEY_CODE_W-1:0] w_win;
  logic                  w_load_ok;
  logic                  w_rpt_fire;
  logic [KEY_CODE_W-1:0] w_rpt_code;

  assign w_rise     = i_btn_lvl & ~r_prev;
  assign w_rise_any = |w_rise;
  assign w_win      = first_key(w_rise);
  assign w_load_ok  = ~r_evt_valid | i_evt_ready;

`ifdef AUTOREPEAT_EN
  logic w_start;
  logic w_abort;
  logic w_trk;

  assign w_start = w_rise_any & ((w_win == KEY_AU) | (w_win == KEY_DIS));
  assign w_abort = w_rise_any & ~w_start;

  key_repeat_timer #(
    .HOLD_CYCLES   (HOLD_CYCLES),
    .REPEAT_CYCLES (REPEAT_CYCLES)
  ) u_key_repeat_timer (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_start  (w_start),
    .i_key    (w_win[0]),
    .i_level  (i_btn_lvl[1:0]),
    .i_abort  (w_abort),
    .o_repeat (w_rpt_fire),
    .o_key    (w_trk)
  );

  assign w_rpt_code = {3'b000, w_trk};
`else
  assign w_rpt_fire = 1'b0;
  assign w_rpt_code = KEY_NONE;
`endif

  // Reset preloads all-ones so a key held through reset must be released before it counts.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_prev      <= '1;
      r_evt_valid <= 1'b0;
      r_evt_code  <= KEY_NONE;
      r_evt_rpt   <= 1'b0;
      r_evt_ovf   <= 1'b0;
    end else begin
      r_prev <= i_btn_lvl;
      if (w_rise_any) begin
        if (w_load_ok) begin
          r_evt_valid <= 1'b1;
          r_evt_code  <= w_win;
          r_evt_rpt   <= 1'b0;
        end else begin
          r_evt_ovf <= 1'b1;
        end
      end else if (w_rpt_fire && w_load_ok) begin
        r_evt_valid <= 1'b1;
        r_evt_code  <= w_rpt_code;
        r_evt_rpt   <= 1'b1;
      end else if (r_evt_valid && i_evt_ready) begin
        r_evt_valid <= 1'b0;
        r_evt_code  <= KEY_NONE;
        r_evt_rpt   <= 1'b0;
      end
    end
  end

  assign o_evt_valid = r_evt_valid;
  assign o_evt_code  = r_evt_code;
  assign o_evt_rpt   = r_evt_rpt;
  assign o_evt_ovf   = r_evt_ovf;

endmodule

// File: doc/button_event_encoder.md
# button_event_encoder

Consumer-side companion to the debounced pushbutton levels of the clock/calendar/timer front panel. It turns the nine stable button levels into single press events (4-bit key code) held under a valid/ready handshake until the control FSM accepts them. It optionally generates timed auto-repeat events for the increment/decrement keys. It sits between the button debouncer and the menu/programming controller.

## Interface
- HOLD_CYCLES, 50_000_000: cycles a repeat key must stay pressed before the first repeat (0.5 s at 100 MHz); must be ≥ 2.
- REPEAT_CYCLES, 10_000_000: cycles between subsequent repeats; must be ≥ 2.
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- btn_lvl  in  9  debounced levels, bit order: 0 au, 1 dis, 2 l, 3 r, 4 f, 5 prh, 6 prf, 7 prc, 8 icr; 1 = pressed.
- evt_ready  in  1  consumer accepts the pending event this cycle.
- evt_valid  out  1  event pending; held until accepted.
- evt_code  out  4  key index 0–8 of the pending event; 4'hF when no event is pending.
- evt_rpt  out  1  pending event is an auto-repeat, not a fresh press.
- evt_ovf  out  1  sticky: a fresh press was lost because an event was pending.

## Operation
- Edge detect: register prev_q <= btn_lvl each cycle; rise = btn_lvl & ~prev_q.
- Priority: on simultaneous rises, the lowest index wins. The other rises are discarded, not queued, and do not set evt_ovf.
- Event register: a new event loads when evt_valid = 0, or when evt_valid & evt_ready (accept and reload in the same cycle is allowed, giving no bubble).
- If a rise occurs while evt_valid = 1 and evt_ready = 0: the event is dropped and evt_ovf <= 1. evt_ovf clears only on reset.
- Accept with no new event: evt_valid <= 0, evt_code <= 4'hF, evt_rpt <= 0.
- Auto-repeat FSM, keys 0 and 1 only. States IDLE, HOLD, REPEAT; counter cnt, width $clog2(max(HOLD_CYCLES, REPEAT_CYCLES)).
  - IDLE → HOLD: the winning rise is key 0 or 1. That key becomes trk and cnt <= 0.
  - HOLD: trk level = 0 → IDLE. cnt = HOLD_CYCLES−1 → emit repeat event, cnt <= 0, go to REPEAT. Otherwise cnt++.
  - REPEAT: trk level = 0 → IDLE. cnt = REPEAT_CYCLES−1 → emit repeat event, cnt <= 0. Otherwise cnt++.
  - Any winning rise while in HOLD or REPEAT: for key 0/1, restart HOLD with the new trk; for any other key, go to IDLE.
  - A repeat event that finds evt_valid pending and not accepted is dropped silently (no evt_ovf). The counter still restarts.
  - A fresh rise and a repeat in the same cycle: the rise wins and the repeat is discarded.
- Reset: prev_q <= 9'h1FF, so a key held through reset produces no event until it is released and pressed again. Also evt_valid = 0, evt_code = 4'hF, evt_rpt = 0, evt_ovf = 0, state IDLE, cnt = 0.
- Reset asserted mid-hold or with an event pending: everything is discarded immediately, with no partial output.

## Timing
- Press latency: btn_lvl rises before edge k → evt_valid = 1 after edge k (1 cycle).
- First repeat: HOLD_CYCLES cycles after the edge that entered HOLD. Later repeats follow every REPEAT_CYCLES cycles.
- Release: trk falling before edge k stops the FSM at edge k. No repeat is emitted on that edge.
- All outputs are registered. No combinational path from evt_ready to any output.

## Configuration
- AUTOREPEAT_EN defined: the FSM, counter and HOLD_CYCLES/REPEAT_CYCLES are active as above.
- AUTOREPEAT_EN undefined: FSM and counter are not built, parameters are ignored, evt_rpt is tied to 0, and only fresh-press events are produced.

## Structure
- Shared package button_pkg holds:
  - NUM_KEYS = 9 and KEY_CODE_W = 4;
  - key indices KEY_AU … KEY_ICR;
  - KEY_NONE = 4'hF;
  - the repeat-state enum (IDLE, HOLD, REPEAT).
- One sub-module, key_repeat_timer, contains the FSM and counter. Inputs: start, key, level, abort. Output: repeat pulse. It is instantiated only under AUTOREPEAT_EN.

## Test plan
- After reset, raise btn_lvl[4] with evt_ready = 0 → evt_valid = 1 and evt_code = 4 on the next edge. Raise evt_ready for 1 cycle → evt_valid = 0 and evt_code = F.
- Raise bits 2 and 7 in the same cycle → one event with code 2. Bit 7 is lost and evt_ovf stays 0.
- Press key 3 without accepting, then press key 5 → evt_code remains 3 and evt_ovf = 1 until reset.
- AUTOREPEAT_EN with HOLD = 8, REPEAT = 4, evt_ready = 1, hold key 0 for 20 cycles:
  - fresh event at cycle 1;
  - repeats (evt_rpt = 1) at cycles 9, 13, 17;
  - none after release.
- Hold key 1 across a reset pulse → no event after reset. Release and press again → code 1 one cycle later.
- Without AUTOREPEAT_EN, hold key 0 for 100 cycles → exactly one event, with evt_rpt = 0.
